// File: rtl/ula32_cond_stage.sv
// Condition/flag stage behind the ula32 ALU: holds the NZCV register, tags each
// result with its condition outcome and forwards it through a 2-entry FIFO.
module ula32_cond_stage #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Result,
  input  logic [3:0]        ALUflags,
  input  logic [3:0]        cond,
  input  logic              set_flags,
  input  logic [TAG_W-1:0]  rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_rd,
  output logic              out_we,
  output logic [3:0]        flags,
  output logic [CNT_W-1:0]  skip_cnt
);

  logic [1:0]        count;
  logic [DATA_W-1:0] head_result, tail_result;
  logic [TAG_W-1:0]  head_rd, tail_rd;
  logic              head_we, tail_we;
  logic              pass;
  logic              push, pop;
  logic              fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags;

  // Conditions test the architectural register, never the incoming ALU flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      4'b0000: pass = fz;
      4'b0001: pass = !fz;
      4'b0010: pass = fc;
      4'b0011: pass = !fc;
      4'b0100: pass = fn;
      4'b0101: pass = !fn;
      4'b0110: pass = fv;
      4'b0111: pass = !fv;
      4'b1000: pass = fc && !fz;
      4'b1001: pass = !fc || fz;
      4'b1010: pass = (fn == fv);
      4'b1011: pass = (fn != fv);
      4'b1100: pass = !fz && (fn == fv);
      4'b1101: pass = fz || (fn != fv);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = head_result;
  assign out_rd     = head_rd;
  assign out_we     = head_we;

  // Head registers drive the outputs directly, so they keep their last value once emptied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= 2'd0;
      head_result <= '0;
      head_rd     <= '0;
      head_we     <= 1'b0;
      tail_result <= '0;
      tail_rd     <= '0;
      tail_we     <= 1'b0;
    end else if (push && pop) begin
      head_result <= Result;
      head_rd     <= rd;
      head_we     <= pass;
    end else if (push) begin
      if (count == 2'd0) begin
        head_result <= Result;
        head_rd     <= rd;
        head_we     <= pass;
      end else begin
        tail_result <= Result;
        tail_rd     <= rd;
        tail_we     <= pass;
      end
      count <= count + 2'd1;
    end else if (pop) begin
      if (count == 2'd2) begin
        head_result <= tail_result;
        head_rd     <= tail_rd;
        head_we     <= tail_we;
      end
      count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags    <= 4'b0000;
      skip_cnt <= '0;
    end else if (push) begin
      if (set_flags && pass)
        flags <= ALUflags;
      if (!pass && (skip_cnt != {CNT_W{1'b1}}))
        skip_cnt <= skip_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ula32_cond_stage.sv
// Directed bench for ula32_cond_stage: a back-to-back vector table plus
// hand-written backpressure, async reset and counter saturation sequences.
module tb_ula32_cond_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Result;
  logic [3:0]  ALUflags;
  logic [3:0]  cond;
  logic        set_flags;
  logic [3:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_we;
  logic [3:0]  flags;
  logic [15:0] skip_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ula32_cond_stage #(.DATA_W(32), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Result(Result), .ALUflags(ALUflags), .cond(cond), .set_flags(set_flags),
    .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .flags(flags), .skip_cnt(skip_cnt)
  );

  typedef struct {
    logic [3:0]  cond;
    logic        setf;
    logic [3:0]  alu;
    logic [31:0] res;
    logic        we;
    logic [3:0]  fl;
    logic [15:0] skip;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic [3:0] c, logic s, logic [3:0] a, logic [31:0] r,
                              logic w, logic [3:0] f, logic [15:0] k);
    vec_t v;
    v.cond = c; v.setf = s; v.alu = a; v.res = r; v.we = w; v.fl = f; v.skip = k;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic s, input logic [3:0] a,
                               input logic [31:0] r, input logic [3:0] t);
    in_valid = 1'b1; cond = c; set_flags = s; ALUflags = a; Result = r; rd = t;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  int          pops;
  logic [3:0]  got[3];
  logic        acc;

  initial begin
    vecs[0]  = mk(4'b1110, 1'b1, 4'b0100, 32'd5,   1'b1, 4'b0100, 16'd0);
    vecs[1]  = mk(4'b0000, 1'b0, 4'b1011, 32'h22,  1'b1, 4'b0100, 16'd0);
    vecs[2]  = mk(4'b0001, 1'b0, 4'b1011, 32'h33,  1'b0, 4'b0100, 16'd1);
    vecs[3]  = mk(4'b1110, 1'b1, 4'b0000, 32'h44,  1'b1, 4'b0000, 16'd1);
    vecs[4]  = mk(4'b0000, 1'b1, 4'b1111, 32'h55,  1'b0, 4'b0000, 16'd2);
    vecs[5]  = mk(4'b1110, 1'b1, 4'b1000, 32'h66,  1'b1, 4'b1000, 16'd2);
    vecs[6]  = mk(4'b1011, 1'b0, 4'b0111, 32'h77,  1'b1, 4'b1000, 16'd2);
    vecs[7]  = mk(4'b1010, 1'b0, 4'b0111, 32'h88,  1'b0, 4'b1000, 16'd3);
    vecs[8]  = mk(4'b1100, 1'b0, 4'b0111, 32'h99,  1'b0, 4'b1000, 16'd4);
    vecs[9]  = mk(4'b1101, 1'b0, 4'b0111, 32'haa,  1'b1, 4'b1000, 16'd4);
    vecs[10] = mk(4'b1110, 1'b1, 4'b1001, 32'hbb,  1'b1, 4'b1001, 16'd4);
    vecs[11] = mk(4'b1010, 1'b0, 4'b0110, 32'hcc,  1'b1, 4'b1001, 16'd4);
    vecs[12] = mk(4'b0100, 1'b0, 4'b0110, 32'hdd,  1'b1, 4'b1001, 16'd4);
    vecs[13] = mk(4'b0101, 1'b0, 4'b0110, 32'hee,  1'b0, 4'b1001, 16'd5);
    vecs[14] = mk(4'b0110, 1'b0, 4'b0110, 32'hff,  1'b1, 4'b1001, 16'd5);
    vecs[15] = mk(4'b0111, 1'b0, 4'b0110, 32'h101, 1'b0, 4'b1001, 16'd6);
    vecs[16] = mk(4'b1110, 1'b1, 4'b0010, 32'h102, 1'b1, 4'b0010, 16'd6);
    vecs[17] = mk(4'b0010, 1'b0, 4'b1101, 32'h103, 1'b1, 4'b0010, 16'd6);
    vecs[18] = mk(4'b0011, 1'b0, 4'b1101, 32'h104, 1'b0, 4'b0010, 16'd7);
    vecs[19] = mk(4'b1000, 1'b0, 4'b1101, 32'h105, 1'b1, 4'b0010, 16'd7);
    vecs[20] = mk(4'b1001, 1'b0, 4'b1101, 32'h106, 1'b0, 4'b0010, 16'd8);
    vecs[21] = mk(4'b1111, 1'b1, 4'b1111, 32'h107, 1'b0, 4'b0010, 16'd9);

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; Result = '0;
    ALUflags = '0; cond = '0; set_flags = 1'b0; rd = '0;
    #12;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_out_rd", {28'd0, out_rd}, 32'd0);
    checkOutput("rst_out_we", {31'd0, out_we}, 32'd0);
    checkOutput("rst_flags", {28'd0, flags}, 32'd0);
    checkOutput("rst_skip", {16'd0, skip_cnt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back table: one accept per cycle, each checked one edge later.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].cond, vecs[i].setf, vecs[i].alu, vecs[i].res, 4'(i));
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("v%0d_result", i), out_result, vecs[i].res);
      checkOutput($sformatf("v%0d_rd", i), {28'd0, out_rd}, 32'(i[3:0]));
      checkOutput($sformatf("v%0d_we", i), {31'd0, out_we}, {31'd0, vecs[i].we});
      checkOutput($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].fl});
      checkOutput($sformatf("v%0d_skip", i), {16'd0, skip_cnt}, {16'd0, vecs[i].skip});
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drain_hold_result", out_result, 32'h107);

    // Backpressure: two accepts fill the buffer, the third waits.
    out_ready = 1'b0;
    applyStimulus(4'b1110, 1'b0, 4'b0000, 32'h1001, 4'd1);
    @(negedge clk);
    applyStimulus(4'b1110, 1'b0, 4'b0000, 32'h1002, 4'd2);
    @(negedge clk);
    checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_head_rd", {28'd0, out_rd}, 32'd1);
    applyStimulus(4'b1110, 1'b0, 4'b0000, 32'h1003, 4'd3);
    @(negedge clk);
    checkOutput("bp_held_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_held_rd", {28'd0, out_rd}, 32'd1);
    out_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 10 && pops < 3; k++) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (pops < 3) got[pops] = out_rd;
        pops++;
      end
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
      @(negedge clk);
    end
    checkOutput("bp_pop_count", 32'(pops), 32'd3);
    checkOutput("bp_pop0", {28'd0, got[0]}, 32'd1);
    checkOutput("bp_pop1", {28'd0, got[1]}, 32'd2);
    checkOutput("bp_pop2", {28'd0, got[2]}, 32'd3);
    checkOutput("bp_empty", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;

    // Async reset with a full buffer and non-zero flags/counter.
    out_ready = 1'b0;
    applyStimulus(4'b1110, 1'b1, 4'b1010, 32'h2001, 4'd7);
    @(negedge clk);
    applyStimulus(4'b1110, 1'b0, 4'b0000, 32'h2002, 4'd8);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("pre_rst_flags", {28'd0, flags}, 32'hA);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("arst_flags", {28'd0, flags}, 32'd0);
    checkOutput("arst_skip", {16'd0, skip_cnt}, 32'd0);
    checkOutput("arst_out_we", {31'd0, out_we}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Counter saturation: every op fails (cond never) and flags must stay clear.
    out_ready = 1'b1;
    applyStimulus(4'b1111, 1'b1, 4'b1111, 32'h3000, 4'd9);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_reach", {16'd0, skip_cnt}, 32'hFFFF);
    @(negedge clk);
    checkOutput("sat_hold", {16'd0, skip_cnt}, 32'hFFFF);
    checkOutput("sat_flags", {28'd0, flags}, 32'd0);
    checkOutput("sat_we", {31'd0, out_we}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
